csc_builder: RTL and testbench

CSC_BUILDER -- requirements
Module: csc_builder

---
 rtl/csc_pkg.sv | 19 +
 rtl/csc_ram.sv | 25 ++
 rtl/csc_builder.sv | 230 +++++++++++++++++++++++
 tb/tb_csc_builder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csc_pkg.sv
// Shared types and codes for the CSC matrix builder: FSM state encoding,
// output beat type codes and a small width helper.
package csc_pkg;

   typedef enum logic [1:0] {
      LOAD     = 2'd0,
      SCAN     = 2'd1,
      EMIT_PTR = 2'd2,
      EMIT_NZ  = 2'd3
   } state_t;

   localparam logic OUT_PTR = 1'b0;
   localparam logic OUT_NZ  = 1'b1;

   function automatic int maxOf(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/csc_ram.sv
// Simple dual-port RAM: one write port, one read port, registered read data
// that only updates when a read is requested (data holds otherwise).
module csc_ram
   import csc_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              i_wrEn,
   input  logic [ADDR_W-1:0] i_wrAddr,
   input  logic [WIDTH-1:0]  i_wrData,
   input  logic              i_rdEn,
   input  logic [ADDR_W-1:0] i_rdAddr,
   output logic [WIDTH-1:0]  o_rdData
);

   logic [WIDTH-1:0] r_mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (i_wrEn) r_mem[i_wrAddr] <= i_wrData;
      if (i_rdEn) o_rdData <= r_mem[i_rdAddr];
   end

endmodule

// File: rtl/csc_builder.sv
// Collects column-ordered complex entries, builds CSC column pointers with a
// prefix-sum scan, then streams the pointer array followed by the non-zeros.
module csc_builder
   import csc_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int MAT_RANK = 256,
   parameter int NNZ_MAX  = 768,
   localparam int IDX_W   = $clog2(MAT_RANK),
   localparam int PTR_W   = $clog2(NNZ_MAX + 1),
   localparam int OUT_W   = maxOf(IDX_W, PTR_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [IDX_W-1:0]  in_row,
   input  logic [IDX_W-1:0]  in_col,
   input  logic [DATA_W-1:0] in_val_r,
   input  logic [DATA_W-1:0] in_val_i,
   input  logic              in_last,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic              out_type,
   output logic [OUT_W-1:0]  out_idx,
   output logic [DATA_W-1:0] out_val_r,
   output logic [DATA_W-1:0] out_val_i,
   output logic              out_last,
   output logic              busy,
   output logic [PTR_W-1:0]  nnz_cnt,
   output logic              err_order,
   output logic              err_ovf
);

   localparam int CNT_W = maxOf(PTR_W, $clog2(MAT_RANK + 1));
   localparam int ENT_W = IDX_W + 2 * DATA_W;
   localparam logic [CNT_W-1:0] RANK_C = CNT_W'(MAT_RANK);
   localparam logic [PTR_W-1:0] NNZ_C  = PTR_W'(NNZ_MAX);

   state_t r_state, w_nextState;

   logic [PTR_W-1:0] r_cnt [MAT_RANK];
   logic [IDX_W-1:0] r_prevRow, r_prevCol;
   logic             r_havePrev;
   logic [CNT_W-1:0] r_scanIdx;
   logic [PTR_W-1:0] r_ptrAcc;
   logic             r_rdRun, r_rdNz;
   logic [CNT_W-1:0] r_rdIdx;
   logic             r_s1Vld, r_s1Type, r_s1PtrEnd, r_s1Last;
   logic             r_outPtrEnd;

   logic             w_accept, w_zero, w_orderBad, w_full, w_store;
   logic             w_outHs, w_done, w_scanEnd, w_load, w_issue;
   logic             w_rdPtrEnd, w_rdNzEnd, w_rdLast;
   logic [CNT_W-1:0] w_nnzExt;
   logic [PTR_W-1:0] w_scanCnt, w_ptrRd;
   logic [ENT_W-1:0] w_entRd;

   assign w_accept   = in_vld && in_rdy;
   assign w_zero     = (in_val_r == '0) && (in_val_i == '0);
   assign w_orderBad = r_havePrev && ((in_col < r_prevCol) ||
                       ((in_col == r_prevCol) && (in_row <= r_prevRow)));
   assign w_full     = (nnz_cnt == NNZ_C);
   assign w_store    = w_accept && !w_zero && !w_orderBad && !w_full;
   assign w_outHs    = out_vld && out_rdy;
   assign w_done     = w_outHs && out_last;
   assign w_scanEnd  = (r_state == SCAN) && (r_scanIdx == RANK_C);
   assign w_scanCnt  = (r_scanIdx < RANK_C) ? r_cnt[r_scanIdx[IDX_W-1:0]] : '0;

   // Two-stage read pipeline (RAM data register, then output register);
   // reads start in the last scan cycle so the first beat lands on time.
   assign w_load     = r_s1Vld && (!out_vld || out_rdy);
   assign w_issue    = (r_rdRun || w_scanEnd) && (!r_s1Vld || w_load);
   assign w_nnzExt   = CNT_W'(nnz_cnt);
   assign w_rdPtrEnd = !r_rdNz && (r_rdIdx == RANK_C);
   assign w_rdNzEnd  = r_rdNz && (r_rdIdx == (w_nnzExt - CNT_W'(1)));
   assign w_rdLast   = w_rdNzEnd || (w_rdPtrEnd && (nnz_cnt == '0));

   csc_ram #(.WIDTH(ENT_W), .ADDR_W(PTR_W)) u_entRam (
      .clk      (clk),
      .i_wrEn   (w_store),
      .i_wrAddr (nnz_cnt),
      .i_wrData ({in_row, in_val_r, in_val_i}),
      .i_rdEn   (w_issue && r_rdNz),
      .i_rdAddr (r_rdIdx[PTR_W-1:0]),
      .o_rdData (w_entRd)
   );

   csc_ram #(.WIDTH(PTR_W), .ADDR_W(CNT_W)) u_ptrRam (
      .clk      (clk),
      .i_wrEn   (r_state == SCAN),
      .i_wrAddr (r_scanIdx),
      .i_wrData (r_ptrAcc),
      .i_rdEn   (w_issue && !r_rdNz),
      .i_rdAddr (r_rdIdx),
      .o_rdData (w_ptrRd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= LOAD;
      else        r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         LOAD:     if (w_accept && in_last) w_nextState = SCAN;
         SCAN:     if (w_scanEnd) w_nextState = EMIT_PTR;
         EMIT_PTR: begin
            if (w_done)                          w_nextState = LOAD;
            else if (w_outHs && r_outPtrEnd)     w_nextState = EMIT_NZ;
         end
         EMIT_NZ:  if (w_done) w_nextState = LOAD;
         default:  w_nextState = LOAD;
      endcase
   end

   always_comb begin
      in_rdy = (r_state == LOAD);
      busy   = (r_state != LOAD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nnz_cnt    <= '0;
         err_order  <= 1'b0;
         err_ovf    <= 1'b0;
         r_havePrev <= 1'b0;
         r_prevRow  <= '0;
         r_prevCol  <= '0;
         for (int c = 0; c < MAT_RANK; c++) r_cnt[c] <= '0;
      end else if (w_done) begin
         nnz_cnt    <= '0;
         err_order  <= 1'b0;
         err_ovf    <= 1'b0;
         r_havePrev <= 1'b0;
         for (int c = 0; c < MAT_RANK; c++) r_cnt[c] <= '0;
      end else if (w_accept && !w_zero) begin
         if (w_orderBad) begin
            err_order <= 1'b1;
         end else if (w_full) begin
            err_ovf <= 1'b1;
         end else begin
            r_cnt[in_col] <= r_cnt[in_col] + PTR_W'(1);
            nnz_cnt       <= nnz_cnt + PTR_W'(1);
            r_prevRow     <= in_row;
            r_prevCol     <= in_col;
            r_havePrev    <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scanIdx <= '0;
         r_ptrAcc  <= '0;
      end else if (r_state == SCAN) begin
         r_scanIdx <= r_scanIdx + CNT_W'(1);
         r_ptrAcc  <= r_ptrAcc + w_scanCnt;
      end else begin
         r_scanIdx <= '0;
         r_ptrAcc  <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdRun    <= 1'b0;
         r_rdNz     <= 1'b0;
         r_rdIdx    <= '0;
         r_s1Vld    <= 1'b0;
         r_s1Type   <= OUT_PTR;
         r_s1PtrEnd <= 1'b0;
         r_s1Last   <= 1'b0;
      end else begin
         if (w_issue) begin
            if (w_rdLast) begin
               r_rdRun <= 1'b0;
               r_rdNz  <= 1'b0;
               r_rdIdx <= '0;
            end else begin
               r_rdRun <= 1'b1;
               if (w_rdPtrEnd) begin
                  r_rdNz  <= 1'b1;
                  r_rdIdx <= '0;
               end else begin
                  r_rdIdx <= r_rdIdx + CNT_W'(1);
               end
            end
            r_s1Vld    <= 1'b1;
            r_s1Type   <= r_rdNz ? OUT_NZ : OUT_PTR;
            r_s1PtrEnd <= w_rdPtrEnd;
            r_s1Last   <= w_rdLast;
         end else if (w_load) begin
            r_s1Vld <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld     <= 1'b0;
         out_type    <= OUT_PTR;
         out_idx     <= '0;
         out_val_r   <= '0;
         out_val_i   <= '0;
         out_last    <= 1'b0;
         r_outPtrEnd <= 1'b0;
      end else if (w_load) begin
         out_vld     <= 1'b1;
         out_type    <= r_s1Type;
         out_last    <= r_s1Last;
         r_outPtrEnd <= r_s1PtrEnd;
         if (r_s1Type == OUT_NZ) begin
            out_idx   <= OUT_W'(w_entRd[ENT_W-1 -: IDX_W]);
            out_val_r <= w_entRd[2*DATA_W-1:DATA_W];
            out_val_i <= w_entRd[DATA_W-1:0];
         end else begin
            out_idx   <= OUT_W'(w_ptrRd);
            out_val_r <= '0;
            out_val_i <= '0;
         end
      end else if (w_outHs) begin
         out_vld     <= 1'b0;
         out_last    <= 1'b0;
         r_outPtrEnd <= 1'b0;
      end
   end

endmodule

// File: tb/tb_csc_builder.sv
// Directed bench for csc_builder (MAT_RANK=4, NNZ_MAX=8): hand-computed CSC
// pointer and non-zero streams, error flags, latency, stalls and mid-stream reset.
module tb_csc_builder;
   import csc_pkg::*;

   localparam int DW = 16;
   localparam int MR = 4;
   localparam int NM = 8;
   localparam int IW = 2;
   localparam int PW = 4;
   localparam int OW = 4;

   logic          clk;
   logic          rst_n;
   logic          in_vld, in_rdy, in_last;
   logic [IW-1:0] in_row, in_col;
   logic [DW-1:0] in_val_r, in_val_i;
   logic          out_vld, out_rdy, out_type, out_last;
   logic [OW-1:0] out_idx;
   logic [DW-1:0] out_val_r, out_val_i;
   logic          busy, err_order, err_ovf;
   logic [PW-1:0] nnz_cnt;

   int checkCount = 0;
   int passCount  = 0;

   logic          expType[$];
   logic [OW-1:0] expIdx[$];
   logic [DW-1:0] expVr[$];
   logic [DW-1:0] expVi[$];

   csc_builder #(.DATA_W(DW), .MAT_RANK(MR), .NNZ_MAX(NM)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_vld    (in_vld),
      .in_rdy    (in_rdy),
      .in_row    (in_row),
      .in_col    (in_col),
      .in_val_r  (in_val_r),
      .in_val_i  (in_val_i),
      .in_last   (in_last),
      .out_vld   (out_vld),
      .out_rdy   (out_rdy),
      .out_type  (out_type),
      .out_idx   (out_idx),
      .out_val_r (out_val_r),
      .out_val_i (out_val_i),
      .out_last  (out_last),
      .busy      (busy),
      .nnz_cnt   (nnz_cnt),
      .err_order (err_order),
      .err_ovf   (err_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      if (obs === exp) passCount++;
      else $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] packBeat(input logic t, input logic [OW-1:0] idx,
                                            input logic [DW-1:0] vr, input logic [DW-1:0] vi,
                                            input logic last);
      return {26'd0, t, idx, (t ? vr : 16'd0), (t ? vi : 16'd0), last};
   endfunction

   task automatic addBeat(input logic t, input int idx, input int vr, input int vi);
      expType.push_back(t);
      expIdx.push_back(OW'(idx));
      expVr.push_back(DW'(vr));
      expVi.push_back(DW'(vi));
   endtask

   task automatic clearExp();
      expType.delete();
      expIdx.delete();
      expVr.delete();
      expVi.delete();
   endtask

   task automatic applyStimulus(input int row, input int col, input int vr, input int vi, input logic last);
      int n;
      @(negedge clk);
      in_row   = IW'(row);
      in_col   = IW'(col);
      in_val_r = DW'(vr);
      in_val_i = DW'(vi);
      in_last  = last;
      in_vld   = 1'b1;
      n = 0;
      while (!in_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_rdy) checkOutput("in_rdy_wait", 64'(in_rdy), 64'(1));
      @(posedge clk);
      #1;
      in_vld  = 1'b0;
      in_last = 1'b0;
   endtask

   // Drains the expected stream with a repeating 4-cycle out_rdy pattern,
   // checking every transferred beat and that stalled payloads hold still.
   task automatic drainBeats(input string tag, input logic [3:0] pat);
      int k;
      int expN;
      bit held;
      logic [63:0] heldWord;
      logic [63:0] nowWord;
      k = 0;
      held = 0;
      heldWord = '0;
      expN = expType.size();
      for (int c = 0; c < 200 && k < expN; c++) begin
         @(negedge clk);
         out_rdy = pat[c % 4];
         if (out_vld) begin
            nowWord = packBeat(out_type, out_idx, out_val_r, out_val_i, out_last);
            if (held) checkOutput({tag, "_hold"}, nowWord, heldWord);
            if (out_rdy) begin
               checkOutput($sformatf("%s_beat%0d", tag, k), nowWord,
                           packBeat(expType[k], expIdx[k], expVr[k], expVi[k], (k == expN - 1)));
               k++;
               held = 0;
            end else begin
               held = 1;
               heldWord = nowWord;
            end
         end
      end
      if (k < expN) checkOutput({tag, "_count"}, 64'(k), 64'(expN));
      out_rdy = 1'b1;
      @(negedge clk);
      checkOutput({tag, "_idle"}, 64'({out_vld, in_rdy, busy, nnz_cnt, err_order, err_ovf}),
                  64'({1'b0, 1'b1, 1'b0, 4'd0, 2'b00}));
   endtask

   initial begin
      int n;
      rst_n    = 1'b0;
      in_vld   = 1'b0;
      in_last  = 1'b0;
      in_row   = '0;
      in_col   = '0;
      in_val_r = '0;
      in_val_i = '0;
      out_rdy  = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_state", 64'({out_vld, out_last, out_type, out_idx, out_val_r, out_val_i,
                                      busy, nnz_cnt, err_order, err_ovf}), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reset_in_rdy", 64'(in_rdy), 64'(1));

      // Basic matrix plus first-beat latency
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(2, 0, 2, 0, 0);
      applyStimulus(1, 2, 0, 3, 1);
      checkOutput("v1_scan", 64'({in_rdy, busy, nnz_cnt}), 64'({1'b0, 1'b1, 4'd3}));
      repeat (MR + 1) @(posedge clk);
      #1;
      checkOutput("v1_lat_early", 64'(out_vld), 64'(0));
      @(posedge clk);
      #1;
      checkOutput("v1_lat_first", 64'(out_vld), 64'(1));
      clearExp();
      addBeat(0, 0, 0, 0); addBeat(0, 2, 0, 0); addBeat(0, 2, 0, 0);
      addBeat(0, 3, 0, 0); addBeat(0, 3, 0, 0);
      addBeat(1, 0, 1, 0); addBeat(1, 2, 2, 0); addBeat(1, 1, 0, 3);
      drainBeats("v1", 4'b1111);

      // Only a zero entry: pointers only, last on the final pointer beat
      applyStimulus(1, 3, 0, 0, 1);
      checkOutput("v2_flags", 64'({err_order, err_ovf, nnz_cnt}), 64'(0));
      clearExp();
      for (int i = 0; i <= MR; i++) addBeat(0, 0, 0, 0);
      drainBeats("v2", 4'b1111);

      // Row order violation within a column
      applyStimulus(2, 1, 5, 0, 0);
      applyStimulus(1, 1, 6, 0, 1);
      checkOutput("v3_flags", 64'({err_order, err_ovf, nnz_cnt}), 64'({1'b1, 1'b0, 4'd1}));
      clearExp();
      addBeat(0, 0, 0, 0); addBeat(0, 0, 0, 0); addBeat(0, 1, 0, 0);
      addBeat(0, 1, 0, 0); addBeat(0, 1, 0, 0);
      addBeat(1, 2, 5, 0);
      drainBeats("v3", 4'b1111);

      // Nine ordered entries into an eight-deep store
      for (int i = 0; i < 8; i++) applyStimulus(i % 4, i / 4, i + 1, 0, 0);
      applyStimulus(0, 2, 9, 0, 1);
      checkOutput("v4_flags", 64'({err_order, err_ovf, nnz_cnt}), 64'({1'b0, 1'b1, 4'd8}));
      clearExp();
      addBeat(0, 0, 0, 0); addBeat(0, 4, 0, 0); addBeat(0, 8, 0, 0);
      addBeat(0, 8, 0, 0); addBeat(0, 8, 0, 0);
      for (int i = 0; i < 8; i++) addBeat(1, i % 4, i + 1, 0);
      drainBeats("v4", 4'b1111);

      // Back-pressure 1,0,0,1 repeating
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(2, 0, 2, 0, 0);
      applyStimulus(1, 2, 0, 3, 1);
      clearExp();
      addBeat(0, 0, 0, 0); addBeat(0, 2, 0, 0); addBeat(0, 2, 0, 0);
      addBeat(0, 3, 0, 0); addBeat(0, 3, 0, 0);
      addBeat(1, 0, 1, 0); addBeat(1, 2, 2, 0); addBeat(1, 1, 0, 3);
      drainBeats("v5", 4'b1001);

      // Reset while non-zero beats are streaming
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(2, 0, 2, 0, 0);
      applyStimulus(1, 2, 0, 3, 1);
      n = 0;
      @(negedge clk);
      while (!(out_vld && out_type) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!(out_vld && out_type)) checkOutput("v6_reach_nz", 64'(out_type), 64'(1));
      rst_n = 1'b0;
      #1;
      checkOutput("v6_rst_now", 64'({out_vld, busy}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("v6_rst_after", 64'({in_rdy, out_vld, nnz_cnt}), 64'({1'b1, 1'b0, 4'd0}));
      applyStimulus(3, 1, 7, 0, 0);
      applyStimulus(0, 2, 8, 1, 1);
      clearExp();
      addBeat(0, 0, 0, 0); addBeat(0, 0, 0, 0); addBeat(0, 1, 0, 0);
      addBeat(0, 2, 0, 0); addBeat(0, 2, 0, 0);
      addBeat(1, 3, 7, 0); addBeat(1, 0, 8, 1);
      drainBeats("v6", 4'b1111);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
